// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register-write controller: frame field positions,
// register address map and controller state encoding.
package spi_regs_pkg;

    localparam int ADDR_EN_OUT_7_0  = 0;
    localparam int ADDR_EN_OUT_15_8 = 1;
    localparam int ADDR_EN_PWM_7_0  = 2;
    localparam int ADDR_EN_PWM_15_8 = 3;
    localparam int ADDR_PWM_DUTY    = 4;

    localparam int FRAME_RW_BIT   = 15;
    localparam int FRAME_ADDR_MSB = 14;
    localparam int FRAME_ADDR_LSB = 8;
    localparam int FRAME_DATA_MSB = 7;
    localparam int FRAME_DATA_LSB = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } ctrl_state_t;

    function automatic logic addr_in_range(input logic [6:0] addr, input int num_regs);
        return int'(addr) < num_regs;
    endfunction

endpackage

// File: rtl/spi_frame_fifo.sv
// Small synchronous frame FIFO; the head entry is presented combinationally and is
// captured into a register by the consumer when it pops.
module spi_frame_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // A push while full is refused even if the same cycle pops.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register-write controller: queues SPI frames, decodes one frame every two clocks and
// updates the PWM configuration registers, shadowing selected ones until a period boundary.
module spi_reg_ctrl
    import spi_regs_pkg::*;
#(
    parameter int                  NUM_REGS   = 5,
    parameter int                  FIFO_DEPTH = 2,
    parameter logic [NUM_REGS-1:0] SYNC_MASK  = 5'b10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic [15:0] frame_data,
    output logic        frame_ready,
    input  logic        period_start,
    output logic [7:0]  en_reg_out_7_0,
    output logic [7:0]  en_reg_out_15_8,
    output logic [7:0]  en_reg_pwm_7_0,
    output logic [7:0]  en_reg_pwm_15_8,
    output logic [7:0]  pwm_duty_cycle,
    output logic        commit_pending,
    output logic        err_addr,
    output logic [7:0]  err_cnt
);
    logic [15:0]         fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    ctrl_state_t         state_reg, state_next;
    logic [15:0]         frame_reg;
    logic                wr_en;
    logic                err_next;
    logic                err_addr_reg;
    logic [7:0]          err_cnt_reg;
    logic [6:0]          frame_addr;
    logic [7:0]          frame_wdata;
    logic [7:0]          active_vec [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_vec;

    spi_frame_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (frame_valid),
        .push_data (frame_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign frame_ready = !fifo_full;
    assign frame_addr  = frame_reg[FRAME_ADDR_MSB:FRAME_ADDR_LSB];
    assign frame_wdata = frame_reg[FRAME_DATA_MSB:FRAME_DATA_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            frame_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (fifo_pop) frame_reg <= fifo_head;
        end
    end

    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        wr_en      = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = ST_IDLE;
                if (frame_reg[FRAME_RW_BIT]) begin
                    if (addr_in_range(frame_addr, NUM_REGS)) wr_en = 1'b1;
                    else                                      err_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic       wr_hit;
            logic [7:0] active_reg;

            assign wr_hit = wr_en && (frame_addr == 7'(gi));

            if (SYNC_MASK[gi]) begin : g_shadow
                logic [7:0] shadow_reg;
                logic       dirty_reg;
                // Commit uses the pre-write shadow; a same-cycle write re-arms dirty.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        active_reg <= '0;
                        shadow_reg <= '0;
                        dirty_reg  <= 1'b0;
                    end else begin
                        if (period_start && dirty_reg) begin
                            active_reg <= shadow_reg;
                            dirty_reg  <= 1'b0;
                        end
                        if (wr_hit) begin
                            shadow_reg <= frame_wdata;
                            dirty_reg  <= 1'b1;
                        end
                    end
                end
                assign dirty_vec[gi] = dirty_reg;
            end else begin : g_direct
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)      active_reg <= '0;
                    else if (wr_hit) active_reg <= frame_wdata;
                end
                assign dirty_vec[gi] = 1'b0;
            end

            assign active_vec[gi] = active_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            err_addr_reg <= err_next;
            if (err_next && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign en_reg_out_7_0  = active_vec[ADDR_EN_OUT_7_0];
    assign en_reg_out_15_8 = active_vec[ADDR_EN_OUT_15_8];
    assign en_reg_pwm_7_0  = active_vec[ADDR_EN_PWM_7_0];
    assign en_reg_pwm_15_8 = active_vec[ADDR_EN_PWM_15_8];
    assign pwm_duty_cycle  = active_vec[ADDR_PWM_DUTY];
    assign commit_pending  = |dirty_vec;
    assign err_addr        = err_addr_reg;
    assign err_cnt         = err_cnt_reg;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: accepted frames go into a scoreboard queue and are
// popped into a behavioural register model when the controller is due to apply them.
module tb_spi_reg_ctrl;

    logic        clk;
    logic        rst_n;
    logic        frame_valid;
    logic [15:0] frame_data;
    logic        frame_ready;
    logic        period_start;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic        commit_pending;
    logic        err_addr;
    logic [7:0]  err_cnt;

    spi_reg_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_valid     (frame_valid),
        .frame_data      (frame_data),
        .frame_ready     (frame_ready),
        .period_start    (period_start),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .commit_pending  (commit_pending),
        .err_addr        (err_addr),
        .err_cnt         (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] TB_SYNC = 5'b10000;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb_q[$];
    logic [7:0]  dut_regs [5];
    logic [7:0]  m_active [5];
    logic [7:0]  m_shadow [5];
    logic [4:0]  m_dirty;
    int          m_err_cnt;
    bit          m_err_last;

    always_comb begin
        dut_regs[0] = en_reg_out_7_0;
        dut_regs[1] = en_reg_out_15_8;
        dut_regs[2] = en_reg_pwm_7_0;
        dut_regs[3] = en_reg_pwm_15_8;
        dut_regs[4] = pwm_duty_cycle;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_active[i] = 8'h00;
            m_shadow[i] = 8'h00;
        end
        m_dirty    = '0;
        m_err_cnt  = 0;
        m_err_last = 0;
        sb_q.delete();
    endtask

    task automatic model_period();
        for (int i = 0; i < 5; i++) begin
            if (m_dirty[i]) m_active[i] = m_shadow[i];
        end
        m_dirty = '0;
    endtask

    task automatic model_pop_apply();
        logic [15:0] f;
        int          a;
        m_err_last = 0;
        if (sb_q.size() == 0) return;
        f = sb_q.pop_front();
        a = int'(f[14:8]);
        if (f[15]) begin
            if (a < 5) begin
                if (TB_SYNC[a]) begin
                    m_shadow[a] = f[7:0];
                    m_dirty[a]  = 1'b1;
                end else begin
                    m_active[a] = f[7:0];
                end
            end else begin
                m_err_last = 1;
                if (m_err_cnt < 255) m_err_cnt++;
            end
        end
    endtask

    // Drives one frame until accepted (bounded) and records it in the scoreboard.
    task automatic send_one(input logic [15:0] f, input string name);
        int waited = 0;
        frame_valid = 1'b1;
        frame_data  = f;
        while (frame_ready !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        n_vec++;
        if (frame_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready: got %b expected 1", name, frame_ready);
        end
        step();
        sb_q.push_back(f);
        frame_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_valid = 1'b0; frame_data = '0; period_start = 1'b0;
        model_reset();
        #2;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (dut_regs[i] !== m_active[i]) begin
                n_err++;
                $display("FAIL reset reg%0d: got %h expected %h", i, dut_regs[i], m_active[i]);
            end
        end
        n_vec++;
        if ({frame_ready, commit_pending, err_addr, err_cnt} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset flags: got rdy=%b pend=%b err=%b cnt=%h expected 1 0 0 00",
                     frame_ready, commit_pending, err_addr, err_cnt);
        end
    endtask

    task automatic test_imm_write();
        send_one(16'h8055, "imm");
        step();
        n_vec++;
        if (en_reg_out_7_0 !== 8'h00) begin
            n_err++;
            $display("FAIL imm early: got %h expected 00", en_reg_out_7_0);
        end
        step();
        model_pop_apply();
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (dut_regs[i] !== m_active[i]) begin
                n_err++;
                $display("FAIL imm reg%0d: got %h expected %h", i, dut_regs[i], m_active[i]);
            end
        end
        n_vec++;
        if (err_addr !== 1'b0) begin
            n_err++;
            $display("FAIL imm err_addr: got %b expected 0", err_addr);
        end
        $display("imm write 8055: reg0=%h", en_reg_out_7_0);
    endtask

    task automatic test_sync_write();
        send_one(16'h84A0, "sync");
        step();
        step();
        model_pop_apply();
        n_vec++;
        if (pwm_duty_cycle !== m_active[4] || commit_pending !== (|m_dirty)) begin
            n_err++;
            $display("FAIL sync pending: got duty=%h pend=%b expected %h %b",
                     pwm_duty_cycle, commit_pending, m_active[4], |m_dirty);
        end
        period_start = 1'b1;
        step();
        period_start = 1'b0;
        model_period();
        n_vec++;
        if (pwm_duty_cycle !== m_active[4] || commit_pending !== (|m_dirty)) begin
            n_err++;
            $display("FAIL sync commit: got duty=%h pend=%b expected %h %b",
                     pwm_duty_cycle, commit_pending, m_active[4], |m_dirty);
        end
        $display("sync write 84A0: duty=%h pending=%b", pwm_duty_cycle, commit_pending);
    endtask

    task automatic test_err_addr();
        int sent = 0;
        bit rdy;
        send_one(16'h8511, "err");
        step();
        step();
        model_pop_apply();
        n_vec++;
        if (err_addr !== m_err_last || err_cnt !== 8'(m_err_cnt)) begin
            n_err++;
            $display("FAIL err pulse: got err=%b cnt=%h expected %b %h",
                     err_addr, err_cnt, m_err_last, 8'(m_err_cnt));
        end
        step();
        n_vec++;
        if (err_addr !== 1'b0) begin
            n_err++;
            $display("FAIL err pulse width: got %b expected 0", err_addr);
        end
        for (int c = 0; c < 2000 && sent < 300; c++) begin
            frame_valid = 1'b1;
            frame_data  = 16'h8511;
            rdy = frame_ready;
            step();
            if (rdy) begin
                sb_q.push_back(16'h8511);
                sent++;
            end
        end
        frame_valid = 1'b0;
        for (int c = 0; c < 20; c++) step();
        while (sb_q.size() > 0) model_pop_apply();
        n_vec++;
        if (sent != 300 || err_cnt !== 8'(m_err_cnt) || frame_ready !== 1'b1) begin
            n_err++;
            $display("FAIL err saturate: got sent=%0d cnt=%h rdy=%b expected 300 %h 1",
                     sent, err_cnt, frame_ready, 8'(m_err_cnt));
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (dut_regs[i] !== m_active[i]) begin
                n_err++;
                $display("FAIL err reg%0d: got %h expected %h", i, dut_regs[i], m_active[i]);
            end
        end
        $display("err flood: err_cnt=%h", err_cnt);
    endtask

    task automatic test_read();
        send_one(16'h0233, "read");
        step();
        step();
        model_pop_apply();
        n_vec++;
        if (en_reg_pwm_7_0 !== m_active[2] || err_cnt !== 8'(m_err_cnt) || err_addr !== 1'b0) begin
            n_err++;
            $display("FAIL read: got reg2=%h cnt=%h err=%b expected %h %h 0",
                     en_reg_pwm_7_0, err_cnt, err_addr, m_active[2], 8'(m_err_cnt));
        end
        $display("read 0233: reg2=%h err_cnt=%h", en_reg_pwm_7_0, err_cnt);
    endtask

    task automatic test_back_to_back();
        logic [15:0] frames [4];
        bit          exp_rdy [5];
        int          sent = 0;
        bit          rdy;
        frames  = '{16'h8011, 16'h8122, 16'h84B0, 16'h84C0};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 9; c++) begin
            frame_valid  = (sent < 4);
            frame_data   = (sent < 4) ? frames[sent] : 16'h0000;
            period_start = (c == 8);
            rdy = frame_ready;
            if (c < 5) begin
                n_vec++;
                if (rdy !== exp_rdy[c]) begin
                    n_err++;
                    $display("FAIL b2b ready c%0d: got %b expected %b", c, rdy, exp_rdy[c]);
                end
            end
            step();
            if (rdy && frame_valid) begin
                sb_q.push_back(frames[sent]);
                sent++;
            end
            period_start = 1'b0;
            if (c == 2 || c == 4 || c == 6 || c == 8) begin
                if (c == 8) model_period();
                model_pop_apply();
                for (int i = 0; i < 5; i++) begin
                    n_vec++;
                    if (dut_regs[i] !== m_active[i]) begin
                        n_err++;
                        $display("FAIL b2b c%0d reg%0d: got %h expected %h", c, i, dut_regs[i], m_active[i]);
                    end
                end
                n_vec++;
                if (commit_pending !== (|m_dirty)) begin
                    n_err++;
                    $display("FAIL b2b c%0d pending: got %b expected %b", c, commit_pending, |m_dirty);
                end
                $display("b2b c%0d: duty=%h pending=%b", c, pwm_duty_cycle, commit_pending);
            end
        end
        frame_valid = 1'b0;
        period_start = 1'b1;
        step();
        period_start = 1'b0;
        model_period();
        n_vec++;
        if (pwm_duty_cycle !== m_active[4] || commit_pending !== 1'b0) begin
            n_err++;
            $display("FAIL b2b final commit: got duty=%h pend=%b expected %h 0",
                     pwm_duty_cycle, commit_pending, m_active[4]);
        end
    endtask

    task automatic test_reset_midflight();
        frame_valid = 1'b1;
        frame_data  = 16'h8077;
        step();
        frame_data  = 16'h8188;
        step();
        frame_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (dut_regs[i] !== m_active[i]) begin
                n_err++;
                $display("FAIL rst async reg%0d: got %h expected %h", i, dut_regs[i], m_active[i]);
            end
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) step();
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (dut_regs[i] !== m_active[i]) begin
                n_err++;
                $display("FAIL rst after reg%0d: got %h expected %h", i, dut_regs[i], m_active[i]);
            end
        end
        n_vec++;
        if ({frame_ready, commit_pending, err_addr, err_cnt} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL rst after flags: got rdy=%b pend=%b err=%b cnt=%h expected 1 0 0 00",
                     frame_ready, commit_pending, err_addr, err_cnt);
        end
        $display("reset mid-flight: reg0=%h reg1=%h ready=%b", en_reg_out_7_0, en_reg_out_15_8, frame_ready);
    endtask

    initial begin
        test_reset();
        test_imm_write();
        test_sync_write();
        test_err_addr();
        test_read();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
